// File: rtl/alu_op_sequencer_if.sv
// Command and response handshake bundle between a host and alu_op_sequencer.
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_operand;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_error;

  // Host side: offers commands, consumes responses.
  modport master (
    output cmd_valid, cmd_op, cmd_operand, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_error
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command-driven controller for the 8-bit ALU datapath: buffers commands in a small FIFO,
// sequences the datapath through load/execute, keeps the accumulator and returns results.
module alu_op_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_on,
  alu_op_sequencer_if.slave   io_bus,
  output logic [2:0]          o_alu_in_sel,
  output logic [7:0]          o_alu_num1,
  output logic [7:0]          o_alu_num2,
  output logic [6:0]          o_alu_out_sel,
  input  logic [7:0]          i_alu_result,
  input  logic                i_alu_overflow,
  output logic [1:0]          o_state,
  output logic                o_error_sticky,
  output logic [7:0]          o_acc
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PtrW:0] CntMax = (PtrW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] StOff    = 2'b00;
  localparam logic [1:0] StReady  = 2'b01;
  localparam logic [1:0] StRun    = 2'b10;
  localparam logic [1:0] StRunErr = 2'b11;

  localparam logic [1:0] PhLoad = 2'b00;
  localparam logic [1:0] PhExec = 2'b01;
  localparam logic [1:0] PhResp = 2'b10;

  localparam logic [2:0] OpAnd = 3'd0;
  localparam logic [2:0] OpOr  = 3'd1;
  localparam logic [2:0] OpNot = 3'd2;
  localparam logic [2:0] OpXor = 3'd3;
  localparam logic [2:0] OpAdd = 3'd4;
  localparam logic [2:0] OpSub = 3'd5;
  localparam logic [2:0] OpMul = 3'd6;
  localparam logic [2:0] OpClr = 3'd7;

  logic [1:0]      r_state;
  logic [1:0]      r_phase;
  logic [2:0]      r_op;
  logic [7:0]      r_operand;
  logic [7:0]      r_acc;
  logic [7:0]      r_rsp_data;
  logic            r_err_sticky;

  logic [2:0]      r_fifo_op  [FIFO_DEPTH];
  logic [7:0]      r_fifo_opd [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0]   r_count;

  logic            w_cmd_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_ovf;
  logic            w_rsp_valid;
  logic            w_rsp_error;
  logic [6:0]      w_op_onehot;

  assign w_cmd_ready = (r_count < CntMax) && (r_state != StOff) && i_on;
  assign w_push      = io_bus.cmd_valid && w_cmd_ready;
  assign w_pop       = (r_state == StReady) && i_on && (r_count != '0);
  assign w_flush     = (r_state == StOff);
  // The overflow line belongs to the multiplier, so only a MUL may turn it into an error.
  assign w_ovf       = i_alu_overflow && (r_op == OpMul);

  // FIFO storage: no reset needed, validity is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_op[r_wr_ptr]  <= io_bus.cmd_op;
      r_fifo_opd[r_wr_ptr] <= io_bus.cmd_operand;
    end
  end

  // FIFO pointers and occupancy; flushed on reset and whenever the controller is off.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Controller state machine, command register, accumulator and response register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StReady;
      r_phase      <= PhLoad;
      r_op         <= OpAnd;
      r_operand    <= 8'h00;
      r_acc        <= 8'h00;
      r_rsp_data   <= 8'h00;
      r_err_sticky <= 1'b0;
    end else begin
      case (r_state)
        StOff: begin
          if (i_on) r_state <= StReady;
        end
        StReady: begin
          if (!i_on) begin
            r_state <= StOff;
          end else if (w_pop) begin
            r_op      <= r_fifo_op[r_rd_ptr];
            r_operand <= r_fifo_opd[r_rd_ptr];
            r_state   <= StRun;
            r_phase   <= PhLoad;
          end
        end
        StRun: begin
          case (r_phase)
            PhLoad: r_phase <= PhExec;
            PhExec: begin
              if (r_op == OpClr) begin
                r_acc      <= 8'h00;
                r_rsp_data <= 8'h00;
                r_phase    <= PhResp;
              end else if (w_ovf) begin
                r_rsp_data   <= i_alu_result;
                r_err_sticky <= 1'b1;
                r_state      <= StRunErr;
              end else begin
                r_acc      <= i_alu_result;
                r_rsp_data <= i_alu_result;
                r_phase    <= PhResp;
              end
            end
            PhResp: begin
              if (io_bus.rsp_ready) r_state <= i_on ? StReady : StOff;
            end
            default: r_state <= StReady;
          endcase
        end
        StRunErr: begin
          if (io_bus.rsp_ready) r_state <= i_on ? StReady : StOff;
        end
        default: r_state <= StReady;
      endcase
    end
  end

  // One-hot output-mux select for the current op; CLR selects no unit.
  always_comb begin
    w_op_onehot = 7'b0000000;
    case (r_op)
      OpAnd:   w_op_onehot = 7'b1000000;
      OpOr:    w_op_onehot = 7'b0100000;
      OpNot:   w_op_onehot = 7'b0010000;
      OpXor:   w_op_onehot = 7'b0001000;
      OpAdd:   w_op_onehot = 7'b0000100;
      OpSub:   w_op_onehot = 7'b0000010;
      OpMul:   w_op_onehot = 7'b0000001;
      default: w_op_onehot = 7'b0000000;
    endcase
  end

  // Datapath selectors and response flags decoded from state and phase.
  always_comb begin
    o_alu_in_sel  = 3'b100;
    o_alu_out_sel = 7'b0000000;
    o_alu_num1    = r_acc;
    o_alu_num2    = 8'h00;
    w_rsp_valid   = 1'b0;
    w_rsp_error   = 1'b0;
    if (r_state == StRun) begin
      case (r_phase)
        PhLoad: begin
          o_alu_in_sel = (r_op == OpClr) ? 3'b001 : 3'b010;
          o_alu_num2   = r_operand;
        end
        PhExec: begin
          o_alu_num2    = r_operand;
          o_alu_out_sel = w_op_onehot;
        end
        PhResp:  w_rsp_valid = 1'b1;
        default: w_rsp_valid = 1'b0;
      endcase
    end else if (r_state == StRunErr) begin
      w_rsp_valid = 1'b1;
      w_rsp_error = 1'b1;
    end
  end

  assign io_bus.cmd_ready = w_cmd_ready;
  assign io_bus.rsp_valid = w_rsp_valid;
  assign io_bus.rsp_error = w_rsp_error;
  assign io_bus.rsp_data  = r_rsp_data;
  assign o_state          = r_state;
  assign o_error_sticky   = r_err_sticky;
  assign o_acc            = r_acc;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural model of the ALU datapath.
module tb_alu_op_sequencer;

  localparam logic [2:0] OpAnd = 3'd0, OpOr = 3'd1, OpNot = 3'd2, OpXor = 3'd3;
  localparam logic [2:0] OpAdd = 3'd4, OpSub = 3'd5, OpMul = 3'd6, OpClr = 3'd7;

  logic       clk;
  logic       rst;
  logic       on;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1;
  logic [7:0] alu_num2;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_result;
  logic       alu_overflow;
  logic [1:0] state;
  logic       error_sticky;
  logic [7:0] acc;

  int total = 0;
  int bad   = 0;

  logic [7:0] q_data[$];
  logic       q_err[$];

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.FIFO_DEPTH(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_on           (on),
    .io_bus         (bus),
    .o_alu_in_sel   (alu_in_sel),
    .o_alu_num1     (alu_num1),
    .o_alu_num2     (alu_num2),
    .o_alu_out_sel  (alu_out_sel),
    .i_alu_result   (alu_result),
    .i_alu_overflow (alu_overflow),
    .o_state        (state),
    .o_error_sticky (error_sticky),
    .o_acc          (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: operand flops behind the input muxes, units behind the output mux.
  logic [7:0]  m_a, m_b;
  logic [15:0] m_prod;
  always @(posedge clk) begin
    case (alu_in_sel)
      3'b010: begin m_a <= alu_num1; m_b <= alu_num2; end
      3'b001: begin m_a <= 8'h00;    m_b <= 8'h00;    end
      default: ;
    endcase
  end
  always_comb begin
    m_prod       = 16'(m_a) * 16'(m_b);
    alu_result   = 8'h00;
    alu_overflow = 1'b0;
    case (alu_out_sel)
      7'b1000000: alu_result = m_a & m_b;
      7'b0100000: alu_result = m_a | m_b;
      7'b0010000: alu_result = ~m_a;
      7'b0001000: alu_result = m_a ^ m_b;
      7'b0000100: alu_result = m_a + m_b;
      7'b0000010: alu_result = m_a - m_b;
      7'b0000001: begin alu_result = m_prod[7:0]; alu_overflow = (m_prod > 16'd255); end
      default:    alu_result = 8'h00;
    endcase
  end

  // Record every completed response handshake (inputs are stable around the negedge).
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      q_data.push_back(bus.rsp_data);
      q_err.push_back(bus.rsp_error);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] opd);
    int n = 0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_operand = opd;
    #1;
    while (!bus.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check("push_ready", 32'(bus.cmd_ready), 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 300 && q_data.size() < n; i++) tick();
    check("rsp_count", q_data.size(), n);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !bus.rsp_valid; i++) tick();
    check("rsp_valid_seen", 32'(bus.rsp_valid), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && state != 2'b01; i++) tick();
    check("idle_state", 32'(state), 1);
  endtask

  initial begin
    logic [7:0] exp6 [6];
    int base;
    exp6 = '{8'h21, 8'h23, 8'h26, 8'h2A, 8'h2F, 8'h35};

    rst = 1'b1; on = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_operand = 8'h00; bus.rsp_ready = 1'b0;
    tick(); tick();

    // Reset values
    check("rst_state", 32'(state), 1);
    check("rst_acc", 32'(acc), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_data", 32'(bus.rsp_data), 0);
    check("rst_rsp_error", 32'(bus.rsp_error), 0);
    check("rst_sticky", 32'(error_sticky), 0);
    check("rst_in_sel", 32'(alu_in_sel), 32'b100);
    check("rst_out_sel", 32'(alu_out_sel), 0);
    check("rst_num1", 32'(alu_num1), 0);
    check("rst_num2", 32'(alu_num2), 0);
    rst = 1'b0;
    tick();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);

    // CLR, ADD 0x25, ADD 0xF0 back-to-back
    bus.rsp_ready = 1'b1;
    push(OpClr, 8'hAA);
    push(OpAdd, 8'h25);
    push(OpAdd, 8'hF0);
    wait_rsp(3);
    check("t1_r0", 32'(q_data[0]), 32'h00);
    check("t1_r1", 32'(q_data[1]), 32'h25);
    check("t1_r2", 32'(q_data[2]), 32'h15);
    check("t1_err", 32'({q_err[0], q_err[1], q_err[2]}), 0);
    wait_idle();
    check("t1_acc", 32'(acc), 32'h15);

    // MUL overflow from acc=0x20
    q_data.delete(); q_err.delete();
    push(OpClr, 8'h00);
    push(OpAdd, 8'h20);
    wait_rsp(2);
    wait_idle();
    bus.rsp_ready = 1'b0;
    push(OpMul, 8'h10);
    wait_valid();
    check("t2_state", 32'(state), 32'b11);
    check("t2_rsp_error", 32'(bus.rsp_error), 1);
    check("t2_rsp_data", 32'(bus.rsp_data), 0);
    check("t2_acc", 32'(acc), 32'h20);
    check("t2_sticky", 32'(error_sticky), 1);
    bus.rsp_ready = 1'b1;
    tick();
    check("t2_state_after", 32'(state), 1);
    check("t2_rsp_logged", 32'(q_err[2]), 1);
    bus.rsp_ready = 1'b0;

    // Six commands with back-pressure
    q_data.delete(); q_err.delete();
    for (int i = 1; i <= 5; i++) push(OpAdd, 8'(i));
    check("t3_full", 32'(bus.cmd_ready), 0);
    bus.cmd_valid = 1'b1; bus.cmd_op = OpAdd; bus.cmd_operand = 8'h06;
    tick(); tick(); tick();
    check("t3_still_full", 32'(bus.cmd_ready), 0);
    check("t3_no_rsp", q_data.size(), 0);
    bus.rsp_ready = 1'b1;
    push(OpAdd, 8'h06);
    check("t3_sixth_after_rsp", 32'(q_data.size() >= 1), 1);
    wait_rsp(6);
    for (int i = 0; i < 6; i++) check($sformatf("t3_r%0d", i), 32'(q_data[i]), 32'(exp6[i]));
    wait_idle();
    check("t3_acc", 32'(acc), 32'h35);

    // ADD 0x07 with rsp_ready low, plus latency
    q_data.delete(); q_err.delete();
    bus.rsp_ready = 1'b0;
    push(OpAdd, 8'h07);
    check("t4_ready_state", 32'(state), 1);
    tick();
    check("t4_load_state", 32'(state), 32'b10);
    check("t4_load_in_sel", 32'(alu_in_sel), 32'b010);
    check("t4_load_num1", 32'(alu_num1), 32'h35);
    check("t4_load_num2", 32'(alu_num2), 32'h07);
    tick();
    check("t4_exec_in_sel", 32'(alu_in_sel), 32'b100);
    check("t4_exec_out_sel", 32'(alu_out_sel), 32'b0000100);
    check("t4_exec_valid", 32'(bus.rsp_valid), 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(bus.rsp_valid), 1);
      check("t4_hold_data", 32'(bus.rsp_data), 32'h3C);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("t4_valid_drop", 32'(bus.rsp_valid), 0);
    tick(); tick(); tick();
    check("t4_one_rsp", q_data.size(), 1);
    check("t4_acc", 32'(acc), 32'h3C);

    // on=0 during EXEC with two commands queued
    q_data.delete(); q_err.delete();
    push(OpAdd, 8'h01);
    push(OpAdd, 8'h02);
    push(OpAdd, 8'h03);
    check("t5_in_exec", 32'(alu_out_sel), 32'b0000100);
    on = 1'b0;
    tick();
    check("t5_rsp_valid", 32'(bus.rsp_valid), 1);
    check("t5_rsp_data", 32'(bus.rsp_data), 32'h3D);
    check("t5_cmd_ready_off", 32'(bus.cmd_ready), 0);
    bus.rsp_ready = 1'b1;
    tick();
    check("t5_state_off", 32'(state), 0);
    tick(); tick(); tick();
    check("t5_still_off", 32'(state), 0);
    check("t5_cmd_ready", 32'(bus.cmd_ready), 0);
    on = 1'b1;
    tick();
    check("t5_state_ready", 32'(state), 1);
    check("t5_cmd_ready_on", 32'(bus.cmd_ready), 1);
    for (int i = 0; i < 6; i++) tick();
    check("t5_dropped", q_data.size(), 1);
    check("t5_idle", 32'(state), 1);
    check("t5_acc", 32'(acc), 32'h3D);

    // rst during LOAD
    q_data.delete(); q_err.delete();
    push(OpAdd, 8'h10);
    tick();
    check("t6_load", 32'(alu_in_sel), 32'b010);
    rst = 1'b1;
    tick();
    check("t6_state", 32'(state), 1);
    check("t6_acc", 32'(acc), 0);
    check("t6_rsp_valid", 32'(bus.rsp_valid), 0);
    check("t6_sticky", 32'(error_sticky), 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t6_no_rsp", q_data.size(), 0);
    check("t6_idle", 32'(state), 1);

    // Remaining ops from acc=0
    q_data.delete(); q_err.delete();
    push(OpNot, 8'h55);
    push(OpXor, 8'h0F);
    push(OpSub, 8'hF1);
    push(OpAnd, 8'h3C);
    push(OpOr,  8'h81);
    push(OpMul, 8'h01);
    wait_rsp(6);
    check("t7_not", 32'(q_data[0]), 32'hFF);
    check("t7_xor", 32'(q_data[1]), 32'hF0);
    check("t7_sub", 32'(q_data[2]), 32'hFF);
    check("t7_and", 32'(q_data[3]), 32'h3C);
    check("t7_or",  32'(q_data[4]), 32'hBD);
    check("t7_mul", 32'(q_data[5]), 32'hBD);
    check("t7_mul_err", 32'(q_err[5]), 0);
    wait_idle();
    check("t7_acc", 32'(acc), 32'hBD);
    check("t7_sticky", 32'(error_sticky), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
